// File: rtl/fetch_stage_pkg.sv
// Shared MIPS pipeline definitions: NOP encoding, instruction field positions
// and jump-target formation.
package fetch_stage_pkg;

    localparam logic [31:0] NOP = 32'h0000_0000;

    localparam int OP_HI    = 31;
    localparam int OP_LO    = 26;
    localparam int RS_HI    = 25;
    localparam int RS_LO    = 21;
    localparam int RT_HI    = 20;
    localparam int RT_LO    = 16;
    localparam int RD_HI    = 15;
    localparam int RD_LO    = 11;
    localparam int SHAMT_HI = 10;
    localparam int SHAMT_LO = 6;
    localparam int FUNCT_HI = 5;
    localparam int FUNCT_LO = 0;
    localparam int IMM_HI   = 15;
    localparam int IMM_LO   = 0;

    // J-type target: upper nibble of the delay-free PC+4, 26-bit index, word aligned.
    function automatic logic [31:0] jump_target(input logic [31:0] pc_plus4,
                                                input logic [31:0] instr);
        return {pc_plus4[31:28], instr[25:0], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry hold register that parks the in-flight fetch word while the
// pipeline is stalled. Clear beats load beats drain.
module fetch_skid_buffer (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        drain,
    input  logic        clear,
    input  logic [31:0] load_instr,
    input  logic [31:0] load_pc_plus4,
    output logic        hold_valid,
    output logic [31:0] hold_instr,
    output logic [31:0] hold_pc_plus4
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_valid <= 1'b0;
        end else if (clear) begin
            hold_valid <= 1'b0;
        end else if (load) begin
            hold_valid <= 1'b1;
        end else if (drain) begin
            hold_valid <= 1'b0;
        end
    end

    // Payload is only meaningful while hold_valid is set, so it carries no reset.
    always_ff @(posedge clk) begin
        if (load && !clear) begin
            hold_instr    <= load_instr;
            hold_pc_plus4 <= load_pc_plus4;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage with IF/ID register: owns the PC, drives a
// 1-cycle-latency instruction memory, survives stalls and flushes on redirects.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] PC_RESET    = 32'h0000_0000,
    parameter int          IMEM_ADDR_W = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall,
    input  logic                   jump,
    input  logic                   branch_taken,
    input  logic [31:0]            branch_target,
    output logic                   imem_en,
    output logic [IMEM_ADDR_W-1:0] imem_addr,
    input  logic [31:0]            imem_rdata,
    output logic                   id_valid,
    output logic [31:0]            id_instr,
    output logic [31:0]            id_pc_plus4,
    output logic [5:0]             op_code,
    output logic [4:0]             rs,
    output logic [4:0]             rt,
    output logic [4:0]             rd,
    output logic [4:0]             shamt,
    output logic [5:0]             funct,
    output logic [15:0]            imm16
);

    logic [31:0] pc_f;
    logic        inflight_valid;
    logic [31:0] inflight_pc;
    logic        hold_valid;
    logic [31:0] hold_instr;
    logic [31:0] hold_pc_plus4;

    logic        flush;
    logic        issue;
    logic [31:0] redirect_pc;

    // A jump only counts when ID holds a real instruction; branch outranks it.
    always_comb begin
        flush       = branch_taken | (jump & id_valid);
        issue       = ~flush & ~stall;
        redirect_pc = branch_taken ? branch_target : jump_target(id_pc_plus4, id_instr);
    end

    assign imem_en   = issue & ~rst;
    assign imem_addr = pc_f[IMEM_ADDR_W+1:2];

    fetch_skid_buffer u_skid (
        .clk          (clk),
        .rst          (rst),
        .load         (stall & inflight_valid & ~flush),
        .drain        (issue & hold_valid),
        .clear        (flush),
        .load_instr   (imem_rdata),
        .load_pc_plus4(inflight_pc + 32'd4),
        .hold_valid   (hold_valid),
        .hold_instr   (hold_instr),
        .hold_pc_plus4(hold_pc_plus4)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_f           <= PC_RESET;
            inflight_valid <= 1'b0;
            id_valid       <= 1'b0;
            id_instr       <= NOP;
            id_pc_plus4    <= 32'h0;
        end else if (flush) begin
            pc_f           <= redirect_pc;
            inflight_valid <= 1'b0;
            id_valid       <= 1'b0;
            id_instr       <= NOP;
        end else if (stall) begin
            inflight_valid <= 1'b0;
        end else begin
            pc_f           <= pc_f + 32'd4;
            inflight_valid <= 1'b1;
            // A parked word is older than the one arriving now, so it goes first.
            if (hold_valid) begin
                id_valid    <= 1'b1;
                id_instr    <= hold_instr;
                id_pc_plus4 <= hold_pc_plus4;
            end else if (inflight_valid) begin
                id_valid    <= 1'b1;
                id_instr    <= imem_rdata;
                id_pc_plus4 <= inflight_pc + 32'd4;
            end else begin
                id_valid    <= 1'b0;
                id_instr    <= NOP;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (issue) begin
            inflight_pc <= pc_f;
        end
    end

    assign op_code = id_instr[OP_HI:OP_LO];
    assign rs      = id_instr[RS_HI:RS_LO];
    assign rt      = id_instr[RT_HI:RT_LO];
    assign rd      = id_instr[RD_HI:RD_LO];
    assign shamt   = id_instr[SHAMT_HI:SHAMT_LO];
    assign funct   = id_instr[FUNCT_HI:FUNCT_LO];
    assign imm16   = id_instr[IMM_HI:IMM_LO];

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset, streaming, stall/hold, jump, branch
// priority, reset during stall, and PC wrap-around on a second instance.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        jump = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic        imem_en;
    logic [9:0]  imem_addr;
    logic [31:0] imem_rdata = 32'h0;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc_plus4;
    logic [5:0]  op_code;
    logic [4:0]  rs, rt, rd, shamt;
    logic [5:0]  funct;
    logic [15:0] imm16;

    logic        w_imem_en;
    logic [9:0]  w_imem_addr;
    logic [31:0] w_imem_rdata = 32'h0;
    logic        w_id_valid;
    logic [31:0] w_id_instr;
    logic [31:0] w_id_pc_plus4;
    logic [5:0]  w_op_code;
    logic [4:0]  w_rs, w_rt, w_rd, w_shamt;
    logic [5:0]  w_funct;
    logic [15:0] w_imm16;
    logic        zero1 = 1'b0;
    logic [31:0] zero32 = 32'h0;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    fetch_stage #(.PC_RESET(32'h0000_0000), .IMEM_ADDR_W(10)) dut (
        .clk(clk), .rst(rst), .stall(stall), .jump(jump),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .id_valid(id_valid), .id_instr(id_instr), .id_pc_plus4(id_pc_plus4),
        .op_code(op_code), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
        .funct(funct), .imm16(imm16)
    );

    fetch_stage #(.PC_RESET(32'hFFFF_FFF8), .IMEM_ADDR_W(10)) dut_wrap (
        .clk(clk), .rst(rst), .stall(zero1), .jump(zero1),
        .branch_taken(zero1), .branch_target(zero32),
        .imem_en(w_imem_en), .imem_addr(w_imem_addr), .imem_rdata(w_imem_rdata),
        .id_valid(w_id_valid), .id_instr(w_id_instr), .id_pc_plus4(w_id_pc_plus4),
        .op_code(w_op_code), .rs(w_rs), .rt(w_rt), .rd(w_rd), .shamt(w_shamt),
        .funct(w_funct), .imm16(w_imm16)
    );

    // Word 3 (byte 0xC) is a j to 0x100; everything else is 0x2000_0000 + index.
    function automatic logic [31:0] mem_word(input logic [9:0] a);
        if (a == 10'd3) return 32'h0800_0040;
        return 32'h2000_0000 + {22'h0, a};
    endfunction

    always @(posedge clk) begin
        if (imem_en)   imem_rdata   <= mem_word(imem_addr);
        if (w_imem_en) w_imem_rdata <= mem_word(w_imem_addr);
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 rst = 1'b1;
        step();
        step();
        check_val("rst_id_valid", {31'h0, id_valid}, 32'h0);
        check_val("rst_id_instr", id_instr, 32'h0);
        check_val("rst_id_pc4", id_pc_plus4, 32'h0);
        check_val("rst_imem_en", {31'h0, imem_en}, 32'h0);
        rst = 1'b0;
        #1;
        check_val("c1_imem_en", {31'h0, imem_en}, 32'h1);
        check_val("c1_imem_addr", {22'h0, imem_addr}, 32'h0);
        check_val("wrap_c1_addr", {22'h0, w_imem_addr}, 32'h3FE);
        step();
        check_val("c1_id_valid", {31'h0, id_valid}, 32'h0);
        check_val("c1_addr_next", {22'h0, imem_addr}, 32'h1);
        step();
        check_val("c2_id_instr", id_instr, 32'h2000_0000);
        check_val("c2_id_pc4", id_pc_plus4, 32'h4);
        check_val("c2_id_valid", {31'h0, id_valid}, 32'h1);
        check_val("c2_op_code", {26'h0, op_code}, 32'h08);
        check_val("wrap_pc4_a", w_id_pc_plus4, 32'hFFFF_FFFC);
        step();
        check_val("c3_id_instr", id_instr, 32'h2000_0001);
        check_val("c3_id_pc4", id_pc_plus4, 32'h8);
        check_val("wrap_pc4_b", w_id_pc_plus4, 32'h0000_0000);

        // Word at PC 8 is now in flight; stall three cycles.
        stall = 1'b1;
        #1;
        check_val("stall_imem_en", {31'h0, imem_en}, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            check_val("stall_id_pc4", id_pc_plus4, 32'h8);
            check_val("stall_id_instr", id_instr, 32'h2000_0001);
            check_val("stall_en", {31'h0, imem_en}, 32'h0);
            if (i == 0) check_val("wrap_pc4_c", w_id_pc_plus4, 32'h4);
        end
        stall = 1'b0;
        #1;
        check_val("rel_imem_en", {31'h0, imem_en}, 32'h1);
        check_val("rel_imem_addr", {22'h0, imem_addr}, 32'h3);
        step();
        check_val("rel_id_pc4_12", id_pc_plus4, 32'hC);
        check_val("rel_id_instr", id_instr, 32'h2000_0002);
        step();
        check_val("rel_id_pc4_16", id_pc_plus4, 32'h10);
        check_val("j_id_instr", id_instr, 32'h0800_0040);
        check_val("j_op_code", {26'h0, op_code}, 32'h02);
        check_val("j_imm16", {16'h0, imm16}, 32'h0040);

        // Jump from ID to 0x100.
        jump = 1'b1;
        #1;
        check_val("j_imem_en", {31'h0, imem_en}, 32'h0);
        step();
        check_val("j_id_valid", {31'h0, id_valid}, 32'h0);
        check_val("j_id_flush", id_instr, 32'h0);
        check_val("j_imem_addr", {22'h0, imem_addr}, 32'h40);
        // jump stays high but ID is empty, so it must be ignored.
        check_val("j_ign_en", {31'h0, imem_en}, 32'h1);
        step();
        jump = 1'b0;
        check_val("j_ign_addr", {22'h0, imem_addr}, 32'h41);
        check_val("j_bubble", {31'h0, id_valid}, 32'h0);
        step();
        check_val("j_tgt_instr", id_instr, 32'h2000_0040);
        check_val("j_tgt_pc4", id_pc_plus4, 32'h104);
        check_val("j_tgt_valid", {31'h0, id_valid}, 32'h1);

        // Branch, jump and stall in one cycle: branch wins and everything flushes.
        branch_taken  = 1'b1;
        branch_target = 32'h0000_0200;
        jump  = 1'b1;
        stall = 1'b1;
        #1;
        check_val("br_imem_en", {31'h0, imem_en}, 32'h0);
        step();
        branch_taken = 1'b0;
        jump  = 1'b0;
        stall = 1'b0;
        #1;
        check_val("br_imem_addr", {22'h0, imem_addr}, 32'h80);
        check_val("br_id_valid", {31'h0, id_valid}, 32'h0);
        check_val("br_id_instr", id_instr, 32'h0);
        step();
        check_val("br_bubble", {31'h0, id_valid}, 32'h0);
        step();
        check_val("br_tgt_instr", id_instr, 32'h2000_0080);
        check_val("br_tgt_pc4", id_pc_plus4, 32'h204);

        // Reset while stalled with a parked word.
        stall = 1'b1;
        step();
        rst = 1'b1;
        #1;
        check_val("mrst_id_valid", {31'h0, id_valid}, 32'h0);
        check_val("mrst_id_instr", id_instr, 32'h0);
        check_val("mrst_id_pc4", id_pc_plus4, 32'h0);
        check_val("mrst_imem_en", {31'h0, imem_en}, 32'h0);
        check_val("mrst_addr", {22'h0, imem_addr}, 32'h0);
        step();
        stall = 1'b0;
        rst = 1'b0;
        #1;
        check_val("mrst_restart", {22'h0, imem_addr}, 32'h0);
        step();
        check_val("mrst_no_hold", {31'h0, id_valid}, 32'h0);
        step();
        check_val("mrst_id_instr0", id_instr, 32'h2000_0000);
        check_val("mrst_id_pc4_4", id_pc_plus4, 32'h4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage plus IF/ID pipeline register for the MIPS pipeline. It owns the PC and drives a synchronous instruction memory with 1-cycle read latency. It holds fetched words across stalls and flushes on jump and branch redirects. It presents the current ID-stage instruction and its fields (Op_code, Funct, Shamt, Rs, Rt) to the decode controller, and takes the controller's Jump back as a redirect.

Parameters:
PC_RESET, 32'h0000_0000, PC value loaded on reset.
IMEM_ADDR_W, 10, word-address width of instruction memory.

Ports:
clk  in  1  pipeline clock, all state on rising edge.
rst  in  1  asynchronous, active-high reset.
stall  in  1  hazard unit: hold PC and IF/ID.
jump  in  1  controller Jump for the instruction now in ID.
branch_taken  in  1  EX-stage branch resolved taken.
branch_target  in  32  byte address of the taken branch.
imem_en  out  1  read request this cycle.
imem_addr  out  IMEM_ADDR_W  word address, pc_f[IMEM_ADDR_W+1:2].
imem_rdata  in  32  word for the previous cycle's request.
id_valid  out  1  IF/ID holds a real instruction.
id_instr  out  32  IF/ID instruction; 32'h0 (NOP) when id_valid=0.
id_pc_plus4  out  32  PC+4 of the ID instruction.
op_code  out  6  id_instr[31:26].
rs  out  5  id_instr[25:21].
rt  out  5  id_instr[20:16].
rd  out  5  id_instr[15:11].
shamt  out  5  id_instr[10:6].
funct  out  6  id_instr[5:0].
imm16  out  16  id_instr[15:0].

Behaviour:
- Reset is asynchronous. pc_f=PC_RESET; inflight_valid, hold_valid, id_valid=0; id_instr=0; id_pc_plus4=0. imem_en=0 while rst=1.
- State: pc_f (next address to request); inflight_valid, inflight_pc (request issued last cycle); hold_valid, hold_instr, hold_pc (1-entry skid buffer).
- Per-cycle priority: branch_taken > jump (only if id_valid=1) > stall > normal.
- Normal (no stall/redirect):
  - imem_en=1 and request pc_f; pc_f<=pc_f+4; inflight_valid<=1; inflight_pc<=pc_f.
  - If hold_valid: IF/ID<=hold entry, hold_valid<=0.
  - Else if inflight_valid: IF/ID<={imem_rdata, inflight_pc+4}, id_valid<=1.
  - Else id_valid<=0.
- Stall:
  - imem_en=0; pc_f and IF/ID unchanged.
  - If inflight_valid: word captured into hold (hold_valid<=1); inflight_valid<=0.
  - Hold never overflows: at most one request is outstanding when stall rises, and no request is issued while stalled.
- Release after stall: the normal rule consumes the hold entry first, concurrently issuing pc_f. No bubble.
- Jump (id_valid=1, no branch_taken):
  - pc_f<={id_pc_plus4[31:28], id_instr[25:0], 2'b00}.
  - id_valid<=0 and id_instr<=0; inflight_valid<=0; hold_valid<=0; imem_en=0 this cycle.
  - No delay slot. First target word reaches ID 2 cycles after the redirect cycle, with no further redirects.
- Branch_taken: same flush behaviour with pc_f<=branch_target; overrides jump and stall in the same cycle.
- Jump with id_valid=0 is ignored.
- Flushes override stall: a redirect during stall clears all buffers.
- PC arithmetic is 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0.
- imem_addr always reflects pc_f, including when imem_en=0.
- Field outputs are combinational slices of id_instr.

Decomposition:
- Shared pipeline package holds:
  - NOP encoding 32'h0.
  - Instruction field bit positions.
  - Jump-target formation function (also used by any later jump-register logic).
- One sub-module is natural: fetch_skid_buffer, the 1-entry hold register with load/drain/clear.

Test Plan:
- Reset, imem returns mem[n]=32'h2000_0000+n: release rst -> cycle 1 imem_addr=0; cycle 2 id_instr=32'h2000_0000, id_pc_plus4=4, id_valid=1; then one word per cycle.
- 3-cycle stall while word at PC 8 is in flight -> that word held; id_instr frozen; imem_en=0 during stall. After release, id_pc_plus4=12 then 16 with no gap or duplicate.
- ID holds 32'h0800_0040 (j), id_pc_plus4=32'h0000_0010, jump=1 -> next cycle id_valid=0, imem_addr=word 0x40; word at 0x100 in ID two cycles after the jump.
- branch_taken=1, target 32'h0000_0200, with jump=1 and stall=1 same cycle -> branch wins; pc_f=0x200; all buffers flushed.
- rst asserted mid-stall with hold_valid=1 -> outputs immediately at reset values; fetch restarts from PC_RESET.
- PC_RESET=32'hFFFF_FFF8 -> PCs FFFF_FFF8, FFFF_FFFC, 0000_0000 in sequence.
